shift_register_universal: RTL

Parametrised universal shift register: the successor to the team's fixed 8-bit serial-in/parallel-out shifter. It supports hold, shift-left, shift-right and parallel-load modes, plus a clock enable, a registered serial output and a saturating count of bits shifted since the last load. It sits between serial bit sources and parallel consumers, and serves equally for parallel-to-serial conversion.

---
 rtl/shift_register_pkg.sv | 14 +
 rtl/shift_counter.sv | 30 +++
 rtl/shift_register_universal.sv | 81 ++++++++
 3 files changed

// File: rtl/shift_register_pkg.sv
// Shared definitions for the universal shift register: modo encodings and counter sizing.
package shift_register_pkg;

  localparam logic [1:0] MODO_MANTER   = 2'b00;
  localparam logic [1:0] MODO_ESQUERDA = 2'b01;
  localparam logic [1:0] MODO_DIREITA  = 2'b10;
  localparam logic [1:0] MODO_CARGA    = 2'b11;

  // Bits needed to hold the values 0..max inclusive.
  function automatic int cnt_width(input int max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating up-counter with synchronous clear and a full decode at MAX.
module shift_counter
  import shift_register_pkg::*;
#(
  parameter int MAX = 8,
  parameter int CW  = cnt_width(MAX)
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          cheio
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX_C)) begin
      count <= count + 1'b1;
    end
  end

  assign cheio = (count == MAX_C);

endmodule

// File: rtl/shift_register_universal.sv
// Universal shift register: hold, shift left/right, parallel load, saturating shift count.
// Optional recirculating shifts are enabled by defining SHIFT_ROTATE_EN.
module shift_register_universal
  import shift_register_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CW          = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             habilita,
  input  logic [1:0]       modo,
  input  logic             novoBit,
  input  logic [WIDTH-1:0] dadoParalelo,
`ifdef SHIFT_ROTATE_EN
  input  logic             rotacao,
`endif
  output logic [WIDTH-1:0] sequencia,
  output logic             bitSaida,
  output logic [CW-1:0]    contagem,
  output logic             cheio
);

  logic             in_left;
  logic             in_right;
  logic [WIDTH-1:0] seq_next;
  logic             bit_next;
  logic             do_shift;
  logic             do_load;

`ifdef SHIFT_ROTATE_EN
  assign in_left  = rotacao ? sequencia[WIDTH-1] : novoBit;
  assign in_right = rotacao ? sequencia[0]       : novoBit;
`else
  assign in_left  = novoBit;
  assign in_right = novoBit;
`endif

  assign do_shift = habilita && ((modo == MODO_ESQUERDA) || (modo == MODO_DIREITA));
  assign do_load  = habilita && (modo == MODO_CARGA);

  always_comb begin
    seq_next = sequencia;
    bit_next = bitSaida;
    if (habilita) begin
      case (modo)
        MODO_ESQUERDA: begin
          seq_next = {sequencia[WIDTH-2:0], in_left};
          bit_next = sequencia[WIDTH-1];
        end
        MODO_DIREITA: begin
          seq_next = {in_right, sequencia[WIDTH-1:1]};
          bit_next = sequencia[0];
        end
        MODO_CARGA: seq_next = dadoParalelo;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      sequencia <= RESET_VALUE;
      bitSaida  <= 1'b0;
    end else begin
      sequencia <= seq_next;
      bitSaida  <= bit_next;
    end
  end

  shift_counter #(.MAX(WIDTH), .CW(CW)) u_counter (
    .clock  (clock),
    .resetN (resetN),
    .clear  (do_load),
    .inc    (do_shift),
    .count  (contagem),
    .cheio  (cheio)
  );

endmodule
